// File: rtl/ctext_pkg.sv
// Shared types and defaults for the ciphertext capture store.
// Default data/address widths and the terminator byte that ends a capture.
package ctext_pkg;

  localparam int         CTEXT_B    = 8;
  localparam int         CTEXT_W    = 4;
  localparam logic [7:0] CTEXT_TERM = 8'h00;

  typedef enum logic {
    FILL = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/ctext_mem.sv
// 2**W x B storage array: write lands on the clock edge, read is combinational.
// A read of the address being written returns the old byte until the edge.
module ctext_mem #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] wa,
  input  logic [B-1:0] wd,
  input  logic [W-1:0] ra,
  output logic [B-1:0] rd
);

  logic [B-1:0] mem [2**W];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/ctext_ram_writer.sv
// Captures cipher bytes into ctext_mem until the terminator or a full array; one byte/cycle, w_ready low in DONE or during clr.
// CTEXT_CHKSUM_EN builds a running XOR of accepted bytes; otherwise chksum reads as zero.
module ctext_ram_writer
  import ctext_pkg::*;
#(
  parameter int         B    = CTEXT_B,
  parameter int         W    = CTEXT_W,
  parameter logic [B-1:0] TERM = B'(CTEXT_TERM)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         w_valid,
  input  logic [B-1:0] w_data,
  output logic         w_ready,
  input  logic [W-1:0] R_A,
  output logic [B-1:0] R_D,
  output logic [W:0]   count,
  output logic         full,
  output logic         done,
  output logic [B-1:0] chksum
);

  // count value at which the next accepted byte fills the array
  localparam logic [W:0] LAST = {1'b0, {W{1'b1}}};

  state_t       state, state_d;
  logic [W-1:0] ptr;
  logic         accept;
  logic         is_term;
  logic         at_last;

  assign accept  = w_valid && w_ready;
  assign is_term = (w_data == TERM);
  assign at_last = (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (clr)
      state_d = FILL;
    else if (state == FILL && accept && (is_term || at_last))
      state_d = DONE;
  end

  always_comb begin
    w_ready = (state == FILL) && !clr;
    done    = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (clr) begin
      ptr   <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (accept) begin
      ptr   <= ptr + 1'b1;
      count <= count + 1'b1;
      if (at_last) full <= 1'b1;
    end
  end

`ifdef CTEXT_CHKSUM_EN
  logic [B-1:0] chk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      chk_q <= '0;
    else if (clr)    chk_q <= '0;
    else if (accept) chk_q <= chk_q ^ w_data;
  end

  assign chksum = chk_q;
`else
  assign chksum = {B{1'b0}};
`endif

  ctext_mem #(.B(B), .W(W)) u_mem (
    .clk (clk),
    .we  (accept),
    .wa  (ptr),
    .wd  (w_data),
    .ra  (R_A),
    .rd  (R_D)
  );

endmodule

// File: tb/tb_ctext_ram_writer.sv
// Scoreboard bench for ctext_ram_writer: stimulus queues expected values, a negedge monitor compares them.
module tb_ctext_ram_writer;

`ifdef CTEXT_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam int S_COUNT = 0;
  localparam int S_FULL  = 1;
  localparam int S_DONE  = 2;
  localparam int S_RDY   = 3;
  localparam int S_RD    = 4;
  localparam int S_CHK   = 5;

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       w_valid;
  logic [7:0] w_data;
  logic       w_ready;
  logic [3:0] R_A;
  logic [7:0] R_D;
  logic [4:0] count;
  logic       full;
  logic       done;
  logic [7:0] chksum;

  chk_t        q[$];
  chk_t        cur;
  logic [15:0] act;
  int          tests = 0;
  int          fails = 0;

  ctext_ram_writer dut (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .w_valid (w_valid),
    .w_data  (w_data),
    .w_ready (w_ready),
    .R_A     (R_A),
    .R_D     (R_D),
    .count   (count),
    .full    (full),
    .done    (done),
    .chksum  (chksum)
  );

  always #5 clk = ~clk;

  // Monitor: everything queued since the last rising edge is compared here
  always @(negedge clk) begin
    while (q.size() > 0) begin
      cur = q.pop_front();
      case (cur.sig)
        S_COUNT: act = {11'b0, count};
        S_FULL:  act = {15'b0, full};
        S_DONE:  act = {15'b0, done};
        S_RDY:   act = {15'b0, w_ready};
        S_RD:    act = {8'b0, R_D};
        default: act = {8'b0, chksum};
      endcase
      tests++;
      if (act !== cur.exp) begin
        fails++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", cur.name, act, cur.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int sig, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    q.push_back(c);
  endtask

  task automatic expect_status(input string tag, input logic [4:0] cnt, input logic f,
                               input logic d, input logic r, input logic [7:0] cs);
    expect_val({tag, ".count"}, S_COUNT, {11'b0, cnt});
    expect_val({tag, ".full"},  S_FULL,  {15'b0, f});
    expect_val({tag, ".done"},  S_DONE,  {15'b0, d});
    expect_val({tag, ".w_ready"}, S_RDY, {15'b0, r});
    expect_val({tag, ".chksum"}, S_CHK,  {8'b0, (CHK_EN ? cs : 8'h00)});
  endtask

  task automatic send(input logic [7:0] b);
    w_valid = 1'b1;
    w_data  = b;
    step();
    w_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; w_valid = 1'b0; w_data = 8'h00; R_A = 4'd0;
    step();
    expect_status("reset", 5'd0, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    reset = 1'b1;
    step();

    // Terminator ends capture
    send(8'h31); send(8'h32); send(8'h31); send(8'h00);
    R_A = 4'd3;
    expect_status("term", 5'd4, 1'b0, 1'b1, 1'b0, 8'h32);
    expect_val("term.rd3", S_RD, 16'h0000);
    step();
    R_A = 4'd1;
    expect_val("term.rd1", S_RD, 16'h0032);
    step();

    // Fill all 16 entries with non-terminator bytes
    do_clr();
    expect_status("clr", 5'd0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 15; i++) send(8'(i));
    expect_status("fill15", 5'd15, 1'b0, 1'b0, 1'b1, 8'h00);
    send(8'h10);
    R_A = 4'd15;
    expect_status("fill16", 5'd16, 1'b1, 1'b1, 1'b0, 8'h10);
    expect_val("fill16.rd15", S_RD, 16'h0010);
    step();
    send(8'h77);
    R_A = 4'd0;
    expect_status("ignored", 5'd16, 1'b1, 1'b1, 1'b0, 8'h10);
    expect_val("ignored.rd0", S_RD, 16'h0001);
    step();

    // clr beats a same-cycle write
    do_clr();
    send(8'h31); send(8'h32);
    w_valid = 1'b1; w_data = 8'hAA; clr = 1'b1;
    expect_val("clrwr.w_ready", S_RDY, 16'h0000);
    step();
    w_valid = 1'b0; clr = 1'b0; R_A = 4'd2;
    expect_status("clrwr", 5'd0, 1'b0, 1'b0, 1'b1, 8'h00);
    expect_val("clrwr.rd2", S_RD, 16'h0003);
    step();

    // Read-during-write returns the old byte first
    R_A = 4'd0; w_valid = 1'b1; w_data = 8'h55;
    expect_val("rdw.old", S_RD, 16'h0031);
    step();
    w_valid = 1'b0;
    expect_val("rdw.new", S_RD, 16'h0055);
    expect_val("rdw.count", S_COUNT, 16'd1);
    step();

    // Asynchronous reset mid-capture
    send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    expect_val("mid.count", S_COUNT, 16'd5);
    step();
    reset = 1'b0;
    expect_status("async", 5'd0, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    reset = 1'b1;
    step();
    send(8'h99);
    R_A = 4'd0;
    expect_status("postrst", 5'd1, 1'b0, 1'b0, 1'b1, 8'h99);
    expect_val("postrst.rd0", S_RD, 16'h0099);
    step();
    R_A = 4'd1;
    expect_val("postrst.rd1", S_RD, 16'h0041);
    step();

    // Checksum over a short message
    do_clr();
    send(8'h31); send(8'h32); send(8'h00);
    expect_status("chk", 5'd3, 1'b0, 1'b1, 1'b0, 8'h03);
    step();

    // Terminator arriving as the 16th byte sets both done and full
    do_clr();
    for (int i = 1; i <= 15; i++) send(8'(i));
    send(8'h00);
    R_A = 4'd15;
    expect_status("termfull", 5'd16, 1'b1, 1'b1, 1'b0, 8'h00);
    expect_val("termfull.rd15", S_RD, 16'h0000);
    step();
    step();

    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
